// File: rtl/itrx_aib_phy_bscan_seq.sv
// itrx_aib_phy_bscan_seq
// Boundary-scan loopback sequencer for the AIB bscan decoder, tck domain.
// Owns the decoder's latched-IR input while a run is active and walks
// CLKSEL, SHIFT_EN, pattern load, TRANSMIT_EN, settle, unload/compare,
// TRANSMIT_DIS and SHIFT_DIS. When idle the TAP's latched IR passes through.
//
// Build option: define AIB_BSCAN_SEQ_INTEST_EN to insert INTEN after XEN and
// INTDIS after XDIS (internal loopback). Undefined gives the plain sequence.
//
// Ports:
//   tck            JTAG clock, all state on posedge
//   reset_n        asynchronous active-low reset
//   tap_ir_latched latched IR from the TAP
//   ir_latched     IR to the bscan decoder (sequencer IR while busy)
//   start          request a run, sampled only in IDLE
//   abort          terminate an active run
//   pattern        load/expected data, captured on start
//   scan_out       serial data into the chain, LSB first, 0 outside LOAD
//   scan_in        serial data from the chain
//   clkdr_en       chain shift clock gate enable
//   busy           run active
//   done           one-cycle completion pulse
//   pass           result of last run, valid from done until next start
//   mismatch_cnt   saturating count of unload mismatches
//
// state  | meaning
// IDLE   | TAP IR passes through, waiting for start
// CLKSEL | issue CLKSEL code
// SHEN   | issue SHIFT_EN code
// LOAD   | shift pattern into chain, CHAIN_LEN cycles
// XEN    | issue TRANSMIT_EN code
// INTEN  | issue internal-loopback enable code (optional)
// SETTLE | hold, SETTLE_CYC cycles
// UNLOAD | shift chain out and compare, CHAIN_LEN cycles
// XDIS   | issue TRANSMIT_DIS code
// INTDIS | issue internal-loopback disable code (optional)
// SHDIS  | issue SHIFT_DIS code
// DONE   | completion pulse, result registered

module itrx_aib_phy_bscan_seq #(
  parameter int LATCHED_IR_WID = 7,
  parameter int CHAIN_LEN      = 16,
  parameter int CNT_WID        = 8,
  parameter int SETTLE_CYC     = 4
) (
  input  logic                      tck,
  input  logic                      reset_n,
  input  logic [LATCHED_IR_WID-1:0] tap_ir_latched,
  output logic [LATCHED_IR_WID-1:0] ir_latched,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CHAIN_LEN-1:0]      pattern,
  output logic                      scan_out,
  input  logic                      scan_in,
  output logic                      clkdr_en,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_WID-1:0]        mismatch_cnt
);

  // The shift/settle counter is sized from the lengths it must count so a
  // narrow mismatch counter cannot truncate the sequence.
  localparam int MAXC = (CHAIN_LEN > SETTLE_CYC) ? CHAIN_LEN : SETTLE_CYC;
  localparam int SW   = $clog2(MAXC);
  localparam int IW   = $clog2(CHAIN_LEN);
  localparam logic [SW-1:0] CHAIN_LAST  = SW'(CHAIN_LEN - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  localparam logic [LATCHED_IR_WID-1:0] IR_HOLD   = LATCHED_IR_WID'(7'h7F);
  localparam logic [LATCHED_IR_WID-1:0] IR_CLKSEL = LATCHED_IR_WID'(7'h18);
  localparam logic [LATCHED_IR_WID-1:0] IR_SHEN   = LATCHED_IR_WID'(7'h0C);
  localparam logic [LATCHED_IR_WID-1:0] IR_XEN    = LATCHED_IR_WID'(7'h0E);
  localparam logic [LATCHED_IR_WID-1:0] IR_INTEN  = LATCHED_IR_WID'(7'h16);
  localparam logic [LATCHED_IR_WID-1:0] IR_XDIS   = LATCHED_IR_WID'(7'h0F);
  localparam logic [LATCHED_IR_WID-1:0] IR_INTDIS = LATCHED_IR_WID'(7'h17);
  localparam logic [LATCHED_IR_WID-1:0] IR_SHDIS  = LATCHED_IR_WID'(7'h0D);

  typedef enum logic [3:0] {
    S_IDLE, S_CLKSEL, S_SHEN, S_LOAD, S_XEN, S_INTEN, S_SETTLE,
    S_UNLOAD, S_XDIS, S_INTDIS, S_SHDIS, S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [SW-1:0]             cnt, cnt_init;
  logic [IW-1:0]             idx;
  logic [CHAIN_LEN-1:0]      shadow;
  logic [LATCHED_IR_WID-1:0] seq_ir, ir_nxt;
  logic                      aborted;

  // State register
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLKSEL;
      S_CLKSEL: state_nxt = S_SHEN;
      S_SHEN:   state_nxt = S_LOAD;
      S_LOAD:   if (cnt == '0) state_nxt = S_XEN;
`ifdef AIB_BSCAN_SEQ_INTEST_EN
      S_XEN:    state_nxt = S_INTEN;
`else
      S_XEN:    state_nxt = S_SETTLE;
`endif
      S_INTEN:  state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_nxt = S_UNLOAD;
      S_UNLOAD: if (cnt == '0) state_nxt = S_XDIS;
`ifdef AIB_BSCAN_SEQ_INTEST_EN
      S_XDIS:   state_nxt = S_INTDIS;
`else
      S_XDIS:   state_nxt = S_SHDIS;
`endif
      S_INTDIS: state_nxt = S_SHDIS;
      S_SHDIS:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // Abort skips straight to the disable tail; once there it is too late.
    if (abort && (state inside {S_CLKSEL, S_SHEN, S_LOAD, S_XEN, S_INTEN,
                                S_SETTLE, S_UNLOAD}))
      state_nxt = S_XDIS;
  end

  // Outputs and per-state datapath controls
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    clkdr_en = (state == S_LOAD) || (state == S_UNLOAD);
    // Down-counter runs LAST..0, so the bit index counts up from 0.
    idx      = IW'(CHAIN_LAST - cnt);
    scan_out = (state == S_LOAD) ? shadow[idx] : 1'b0;

    cnt_init = '0;
    if (state_nxt == S_LOAD || state_nxt == S_UNLOAD) cnt_init = CHAIN_LAST;
    else if (state_nxt == S_SETTLE)                   cnt_init = SETTLE_LAST;

    // seq_ir is registered from the upcoming state so it lines up with it.
    case (state_nxt)
      S_CLKSEL: ir_nxt = IR_CLKSEL;
      S_SHEN:   ir_nxt = IR_SHEN;
      S_XEN:    ir_nxt = IR_XEN;
      S_INTEN:  ir_nxt = IR_INTEN;
      S_XDIS:   ir_nxt = IR_XDIS;
      S_INTDIS: ir_nxt = IR_INTDIS;
      S_SHDIS:  ir_nxt = IR_SHDIS;
      default:  ir_nxt = IR_HOLD;
    endcase
  end

  assign ir_latched = busy ? seq_ir : tap_ir_latched;

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      seq_ir       <= IR_HOLD;
      cnt          <= '0;
      shadow       <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      seq_ir <= ir_nxt;
      if (state_nxt != state) cnt <= cnt_init;
      else if (cnt != '0)     cnt <= cnt - 1'b1;

      if (state == S_IDLE && start) begin
        shadow       <= pattern;
        mismatch_cnt <= '0;
        pass         <= 1'b0;
        aborted      <= 1'b0;
      end else begin
        if (state == S_UNLOAD && scan_in != shadow[idx] && mismatch_cnt != '1)
          mismatch_cnt <= mismatch_cnt + 1'b1;
        if (state == S_SHDIS)
          pass <= (mismatch_cnt == '0) && !aborted;
        // A late abort still spoils the result, overriding the line above.
        if (busy && abort) begin
          aborted <= 1'b1;
          pass    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_itrx_aib_phy_bscan_seq.sv
module tb_itrx_aib_phy_bscan_seq;

  localparam int CL = 16;
`ifdef AIB_BSCAN_SEQ_INTEST_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        tck, reset_n, start, abort, scan_in, scan_in3;
  logic [6:0]  tap_ir, ir, ir3;
  logic [15:0] pattern;
  logic        scan_out, clkdr_en, busy, done, pass;
  logic        so3, ck3, busy3, done3, pass3;
  logic [7:0]  mis;
  logic [2:0]  mis3;

  itrx_aib_phy_bscan_seq dut (
    .tck(tck), .reset_n(reset_n), .tap_ir_latched(tap_ir), .ir_latched(ir),
    .start(start), .abort(abort), .pattern(pattern), .scan_out(scan_out),
    .scan_in(scan_in), .clkdr_en(clkdr_en), .busy(busy), .done(done),
    .pass(pass), .mismatch_cnt(mis));

  itrx_aib_phy_bscan_seq #(.CNT_WID(3)) dut3 (
    .tck(tck), .reset_n(reset_n), .tap_ir_latched(tap_ir), .ir_latched(ir3),
    .start(start), .abort(abort), .pattern(pattern), .scan_out(so3),
    .scan_in(scan_in3), .clkdr_en(ck3), .busy(busy3), .done(done3),
    .pass(pass3), .mismatch_cnt(mis3));

  initial tck = 1'b0;
  always #5 tck = ~tck;

  typedef struct { logic [6:0] ir; logic ck; logic so; } cyc_t;
  typedef struct { logic pass; int mis; logic pass3; int mis3; int len; } res_t;

  cyc_t        cyc_q[$];
  res_t        res_q[$];
  int          n_chk, n_fail;
  logic [15:0] cur_pat;
  bit          fault_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chain model: after the 16 load shifts, the next 16 shifts return bit k.
  int chain_k;
  always @(negedge tck) begin
    if (!busy) chain_k = 0;
    else if (clkdr_en) begin
      if (chain_k >= CL) begin
        scan_in  = fault_mode ? 1'b0 : cur_pat[chain_k - CL];
        scan_in3 = ~scan_in;
      end
      chain_k++;
    end
  end

  // Monitor: per-cycle expectations while busy, result on done, pass-through when idle.
  int busy_cnt;
  always @(negedge tck) begin
    cyc_t c;
    res_t r;
    if (busy && !done) begin
      busy_cnt++;
      if (cyc_q.size() == 0) chk("busy_unexpected", busy, 0);
      else begin
        c = cyc_q.pop_front();
        chk("ir_latched", ir, c.ir);
        chk("clkdr_en", clkdr_en, c.ck);
        chk("scan_out", scan_out, c.so);
      end
    end else if (done) begin
      if (res_q.size() == 0) chk("done_unexpected", done, 0);
      else begin
        r = res_q.pop_front();
        chk("pass", pass, r.pass);
        chk("mismatch_cnt", mis, r.mis);
        chk("pass_w3", pass3, r.pass3);
        chk("mismatch_cnt_w3", mis3, r.mis3);
        chk("run_len", busy_cnt, r.len);
        chk("done_w3", done3, 1);
      end
    end else begin
      busy_cnt = 0;
      chk("ir_passthru", ir, tap_ir);
      chk("clkdr_idle", clkdr_en, 0);
      chk("scan_out_idle", scan_out, 0);
    end
  end

  function automatic void pc(input logic [6:0] i, input logic k, input logic s);
    cyc_t c;
    c.ir = i; c.ck = k; c.so = s;
    cyc_q.push_back(c);
  endfunction

  task automatic expect_run(input logic [15:0] pat, input int abort_at,
                            input logic ep, input int em, input logic ep3, input int em3);
    res_t r;
    pc(7'h18, 0, 0);
    pc(7'h0C, 0, 0);
    if (abort_at < 0) begin
      for (int k = 0; k < CL; k++) pc(7'h7F, 1, pat[k]);
      pc(7'h0E, 0, 0);
      if (EXTRA == 1) pc(7'h16, 0, 0);
      for (int k = 0; k < 4; k++) pc(7'h7F, 0, 0);
      for (int k = 0; k < CL; k++) pc(7'h7F, 1, 0);
      r.len = 41 + 2 * EXTRA;
    end else begin
      for (int k = 0; k <= abort_at; k++) pc(7'h7F, 1, pat[k]);
      r.len = 2 + abort_at + 1 + 2 + EXTRA;
    end
    pc(7'h0F, 0, 0);
    if (EXTRA == 1) pc(7'h17, 0, 0);
    pc(7'h0D, 0, 0);
    r.pass = ep; r.mis = em; r.pass3 = ep3; r.mis3 = em3;
    res_q.push_back(r);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge tck);
      n++;
    end
    chk("done_timeout", done, 1);
    @(posedge tck); #1;
    chk("res_q_drained", res_q.size(), 0);
    chk("cyc_q_drained", cyc_q.size(), 0);
    tap_ir = 7'h12;
    repeat (3) @(posedge tck);
  endtask

  task automatic run(input logic [15:0] pat, input bit fault, input int abort_at,
                     input bit restart, input bit abort_with_start,
                     input logic ep, input int em, input logic ep3, input int em3);
    expect_run(pat, abort_at, ep, em, ep3, em3);
    cur_pat = pat; fault_mode = fault; pattern = pat;
    @(posedge tck); #1;
    start = 1'b1;
    abort = abort_with_start;
    @(posedge tck); #1;
    start = 1'b0;
    abort = 1'b0;
    pattern = ~pat;
    tap_ir = 7'h33;
    if (abort_at >= 0) begin
      repeat (2 + abort_at) @(posedge tck);
      #1 abort = 1'b1;
      @(posedge tck);
      #1 abort = 1'b0;
    end
    if (restart) begin
      repeat (5) @(posedge tck);
      #1 start = 1'b1;
      repeat (2) @(posedge tck);
      #1 start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; busy_cnt = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0;
    tap_ir = 7'h12; scan_in = 1'b0; scan_in3 = 1'b0;
    cur_pat = '0; fault_mode = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mismatch", mis, 0);
    chk("rst_scan_out", scan_out, 0);
    chk("rst_clkdr", clkdr_en, 0);
    chk("rst_ir", ir, 7'h12);
    reset_n = 1'b1;
    repeat (5) @(posedge tck);

    // good, fault, abort at LOAD count 5, start+abort together, restart ignored
    run(16'hA5C3, 0, -1, 0, 0, 1, 0, 0, 7);
    run(16'hA5C3, 1, -1, 0, 0, 0, 8, 0, 7);
    run(16'hA5C3, 0,  5, 0, 0, 0, 0, 0, 0);
    run(16'h3C5A, 0, -1, 0, 1, 1, 0, 0, 7);
    run(16'h8001, 0, -1, 1, 0, 1, 0, 0, 7);

    // reset during SETTLE, then a fresh run
    expect_run(16'hA5C3, -1, 1, 0, 0, 7);
    cur_pat = 16'hA5C3; fault_mode = 1'b0; pattern = 16'hA5C3;
    @(posedge tck); #1 start = 1'b1;
    @(posedge tck); #1 start = 1'b0;
    repeat (21) @(posedge tck);
    #1 reset_n = 1'b0;
    cyc_q.delete();
    res_q.delete();
    tap_ir = 7'h21;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ir", ir, 7'h21);
    chk("midrst_clkdr", clkdr_en, 0);
    @(posedge tck); #1 reset_n = 1'b1;
    repeat (2) @(posedge tck);
    run(16'hA5C3, 0, -1, 0, 0, 1, 0, 0, 7);

    // every unload bit zero against all-ones pattern: 16 in the wide counter,
    // while the narrow instance sees its inverted input match
    run(16'hFFFF, 1, -1, 0, 0, 0, 16, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
